npu_cmd_dispatch: RTL and testbench
===================================

Name: npu_cmd_dispatch

Overview:
- Sits directly downstream of the softcore EXECUTE stage.
- Consumes the one-cycle custom-instruction start pulse and the 32-bit custom instruction word, buffers them in a small FIFO, and issues them one at a time to the NPU command port with a valid/ready handshake.
- Captures the NPU result and returns it to the core writeback path through a valid/ready response port.
- Supplies the stall signal the core needs when the queue is nearly full.

Parameters:
DATA_WIDTH, 32, width of instruction and result words
DEPTH, 4, command FIFO entries; power of two, minimum 2
TIMEOUT_CYCLES, 1024, WAIT cycles before timeout abort (used only with the optional feature)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_start  in  1  one-cycle pulse from core: push cmd_instr
cmd_instr  in  DATA_WIDTH  custom instruction word
cmd_full  out  1  stall request to core: FIFO count >= DEPTH-1
npu_cmd_valid  out  1  command offered to NPU
npu_cmd_data  out  DATA_WIDTH  command word (FIFO head)
npu_cmd_ready  in  1  NPU accepts command
npu_result  in  DATA_WIDTH  NPU result word
npu_result_valid  in  1  result strobe, one cycle
rsp_valid  out  1  result available to core
rsp_data  out  DATA_WIDTH  captured result
rsp_ready  in  1  core consumes result
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
err_overflow  out  1  sticky: push dropped while full
err_timeout  out  1  sticky: NPU result timeout
err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count = 0; FSM = IDLE.
  - All outputs 0: npu_cmd_valid, npu_cmd_data, rsp_valid, rsp_data, cmd_full, busy, fifo_count, err_overflow, err_timeout.
  - Reset mid-transaction discards queued and in-flight commands. No response is produced for them.
- FIFO push:
  - cmd_start=1 with count < DEPTH: write at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
  - cmd_start=1 with count == DEPTH: word dropped and err_overflow set, even if a pop occurs in the same cycle.
- FIFO pop: only on the ISSUE-state handshake (npu_cmd_valid && npu_cmd_ready).
- Simultaneous push and pop with count < DEPTH: both happen, count unchanged.
- Pointers wrap modulo DEPTH.
- cmd_full is combinational from count (count >= DEPTH-1). This gives the core one cycle of slack for an in-flight pulse.
- FSM states:
  - IDLE:
    - count != 0 -> ISSUE.
    - npu_cmd_data is loaded from the FIFO head on this transition (registered output).
  - ISSUE:
    - npu_cmd_valid=1; npu_cmd_data held stable until accepted.
    - npu_cmd_ready=1 -> pop, deassert valid, go to WAIT.
  - WAIT:
    - npu_result_valid=1 -> rsp_data <= npu_result, rsp_valid <= 1, go to RESPOND.
  - RESPOND:
    - rsp_valid and rsp_data held stable until rsp_ready=1.
    - Then rsp_valid <= 0 and go to IDLE.
- npu_result_valid outside WAIT is ignored.
- One command is in flight at a time. Responses are returned in issue order.
- Latency, with empty FIFO and idle FSM:
  - Push sampled at edge N.
  - npu_cmd_valid high after edge N+1.
  - With npu_cmd_ready tied high, the pop happens at edge N+2.
  - rsp_valid is high on the edge after npu_result_valid is sampled.
- busy = (state != IDLE) || (count != 0).
- err_clr has priority below a same-cycle error set: the set wins.

Optional Feature:
- Macro: NPU_CMD_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no result, go to RESPOND with rsp_data=32'hFFFF_FFFF and set err_timeout.
  - A result arriving in that same cycle takes priority over the timeout.
- When not defined: WAIT persists indefinitely and err_timeout is tied 0.

Test Plan:
- Single command: pulse cmd_start with cmd_instr=32'h0000_00FB, npu_cmd_ready=1, npu_result=32'h1234_5678 three cycles later -> npu_cmd_valid high after edge N+1 with data 32'h0000_00FB; rsp_valid=1 with rsp_data=32'h1234_5678 held until rsp_ready.
- Back-pressure: npu_cmd_ready=0 for 5 cycles -> npu_cmd_valid stays 1, npu_cmd_data stable, fifo_count stays 1; pop on the first ready cycle.
- Overflow: DEPTH=4, npu_cmd_ready=0, 5 pushes of 1..5 -> cmd_full=1 from count 3; fifo_count=4; err_overflow=1; the NPU later receives 1,2,3,4 in order; err_clr returns err_overflow to 0.
- Wrap-around: 10 commands streamed with random ready/result gaps -> all 10 results returned in order; fifo_count never exceeds 4.
- Reset mid-operation: assert rst_n low during WAIT with 2 queued commands -> all outputs 0 immediately (asynchronous); after release, a stray npu_result_valid produces no rsp_valid.
- Timeout (NPU_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): no result -> after 16 WAIT cycles rsp_data=32'hFFFF_FFFF and err_timeout=1; without the macro, rsp_valid stays 0.

Source files
------------

// File: rtl/npu_cmd_dispatch.sv
// NPU command dispatcher: queues custom instructions from EXECUTE, issues them one at a
// time to the NPU and returns results in order. Optional result timeout: NPU_CMD_TIMEOUT_EN.
module npu_cmd_dispatch #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_start,
    input  logic [DATA_WIDTH-1:0]        cmd_instr,
    output logic                         cmd_full,
    output logic                         npu_cmd_valid,
    output logic [DATA_WIDTH-1:0]        npu_cmd_data,
    input  logic                         npu_cmd_ready,
    input  logic [DATA_WIDTH-1:0]        npu_result,
    input  logic                         npu_result_valid,
    output logic                         rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    input  logic                         rsp_ready,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         err_overflow,
    output logic                         err_timeout,
    input  logic                         err_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic                    r_cmd_valid;
    logic                    w_cmd_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_cmd_data;
    logic [DATA_WIDTH-1:0]   w_cmd_data_nxt;
    logic                    r_rsp_valid;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [DATA_WIDTH-1:0]   w_rsp_data_nxt;
    logic                    r_err_ov;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_pop;

`ifdef NPU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    logic [TW-1:0]           r_wait_cnt;
    logic [TW-1:0]           w_wait_cnt_nxt;
    logic                    w_timeout;
    logic                    r_err_to;
`endif

    // A push into a full queue is dropped even when a pop frees a slot in the same cycle.
    assign w_push = cmd_start && (r_count != CNT_FULL);
    assign w_drop = cmd_start && (r_count == CNT_FULL);
    assign w_pop  = (r_state == S_ISSUE) && r_cmd_valid && npu_cmd_ready;

    // Occupancy update from push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= cmd_instr;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Next-state and next registered-output logic of the dispatch FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_data_nxt  = r_cmd_data;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
`ifdef NPU_CMD_TIMEOUT_EN
        w_wait_cnt_nxt  = r_wait_cnt;
        w_timeout       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_count != CNT_ZERO) begin
                    w_state_nxt     = S_ISSUE;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_data_nxt  = r_mem[r_rd_ptr];
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (npu_cmd_ready) begin
                    w_state_nxt     = S_WAIT;
                    w_cmd_valid_nxt = 1'b0;
`ifdef NPU_CMD_TIMEOUT_EN
                    w_wait_cnt_nxt  = {TW{1'b0}};
`endif
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (npu_result_valid) begin
                    w_state_nxt     = S_RESPOND;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = npu_result;
                end
`ifdef NPU_CMD_TIMEOUT_EN
                else if (r_wait_cnt == TO_LAST) begin
                    w_state_nxt     = S_RESPOND;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = {DATA_WIDTH{1'b1}};
                    w_timeout       = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + TO_ONE;
                end
`else
                else begin
                    w_state_nxt = S_WAIT;
                end
`endif
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RESPOND;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_cmd_valid_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= {DATA_WIDTH{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    // Sticky overflow flag; a same-cycle set beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ov <= 1'b0;
        end else if (w_drop) begin
            r_err_ov <= 1'b1;
        end else if (err_clr) begin
            r_err_ov <= 1'b0;
        end else begin
            r_err_ov <= r_err_ov;
        end
    end

`ifdef NPU_CMD_TIMEOUT_EN
    // WAIT-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= {TW{1'b0}};
            r_err_to   <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout) begin
                r_err_to <= 1'b1;
            end else if (err_clr) begin
                r_err_to <= 1'b0;
            end else begin
                r_err_to <= r_err_to;
            end
        end
    end

    assign err_timeout = r_err_to;
`else
    logic w_unused;
    assign w_unused    = (TIMEOUT_CYCLES > 0);
    assign err_timeout = 1'b0;
`endif

    assign cmd_full      = (r_count >= CNT_AF);
    assign busy          = (r_state != S_IDLE) || (r_count != CNT_ZERO);
    assign fifo_count    = r_count;
    assign npu_cmd_valid = r_cmd_valid;
    assign npu_cmd_data  = r_cmd_data;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign err_overflow  = r_err_ov;

endmodule

// File: tb/tb_npu_cmd_dispatch.sv
// Directed self-checking bench for npu_cmd_dispatch (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_npu_cmd_dispatch;

    logic        clk;
    logic        rst_n;
    logic        cmd_start;
    logic [31:0] cmd_instr;
    logic        cmd_full;
    logic        npu_cmd_valid;
    logic [31:0] npu_cmd_data;
    logic        npu_cmd_ready;
    logic [31:0] npu_result;
    logic        npu_result_valid;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        err_overflow;
    logic        err_timeout;
    logic        err_clr;

    int passed = 0;
    int total  = 0;

    npu_cmd_dispatch #(
        .DATA_WIDTH     (32),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_start        (cmd_start),
        .cmd_instr        (cmd_instr),
        .cmd_full         (cmd_full),
        .npu_cmd_valid    (npu_cmd_valid),
        .npu_cmd_data     (npu_cmd_data),
        .npu_cmd_ready    (npu_cmd_ready),
        .npu_result       (npu_result),
        .npu_result_valid (npu_result_valid),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_ready        (rsp_ready),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .err_overflow     (err_overflow),
        .err_timeout      (err_timeout),
        .err_clr          (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, npu_cmd_valid, 32'd0);
        chk({tag, "_cmd_data"},  npu_cmd_data,  32'd0);
        chk({tag, "_rsp_valid"}, rsp_valid,     32'd0);
        chk({tag, "_rsp_data"},  rsp_data,      32'd0);
        chk({tag, "_cmd_full"},  cmd_full,      32'd0);
        chk({tag, "_busy"},      busy,          32'd0);
        chk({tag, "_count"},     fifo_count,    32'd0);
        chk({tag, "_err_ov"},    err_overflow,  32'd0);
        chk({tag, "_err_to"},    err_timeout,   32'd0);
    endtask

    initial begin
        int sent;
        int issued;
        int rsp_n;
        int pend;
        int gap;
        int max_cnt;
        logic [31:0] inflight;

        rst_n = 1'b0; cmd_start = 1'b0; cmd_instr = 32'd0; npu_cmd_ready = 1'b0;
        npu_result = 32'd0; npu_result_valid = 1'b0; rsp_ready = 1'b0; err_clr = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single command with ready tied high
        cmd_start = 1'b1; cmd_instr = 32'h0000_00FB; npu_cmd_ready = 1'b1;
        step();
        cmd_start = 1'b0;
        chk("single_cnt_after_push", fifo_count, 32'd1);
        chk("single_valid_n0", npu_cmd_valid, 32'd0);
        chk("single_busy", busy, 32'd1);
        step();
        chk("single_valid_n1", npu_cmd_valid, 32'd1);
        chk("single_data_n1", npu_cmd_data, 32'h0000_00FB);
        step();
        chk("single_valid_after_pop", npu_cmd_valid, 32'd0);
        chk("single_cnt_after_pop", fifo_count, 32'd0);
        npu_cmd_ready = 1'b0;
        step();
        npu_result_valid = 1'b1; npu_result = 32'h1234_5678;
        step();
        npu_result_valid = 1'b0;
        chk("single_rsp_valid", rsp_valid, 32'd1);
        chk("single_rsp_data", rsp_data, 32'h1234_5678);
        step();
        step();
        chk("single_rsp_hold_valid", rsp_valid, 32'd1);
        chk("single_rsp_hold_data", rsp_data, 32'h1234_5678);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("single_rsp_done", rsp_valid, 32'd0);
        chk("single_idle", busy, 32'd0);

        // Back-pressure on the command port
        cmd_start = 1'b1; cmd_instr = 32'h0000_00AA;
        step();
        cmd_start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", npu_cmd_valid, 32'd1);
            chk("bp_data", npu_cmd_data, 32'h0000_00AA);
            chk("bp_count", fifo_count, 32'd1);
            step();
        end
        npu_cmd_ready = 1'b1;
        step();
        npu_cmd_ready = 1'b0;
        chk("bp_popped_valid", npu_cmd_valid, 32'd0);
        chk("bp_popped_count", fifo_count, 32'd0);
        npu_result_valid = 1'b1; npu_result = 32'h0000_00BB;
        step();
        npu_result_valid = 1'b0; rsp_ready = 1'b1;
        chk("bp_rsp_data", rsp_data, 32'h0000_00BB);
        step();
        rsp_ready = 1'b0;

        // Overflow: five pushes into a four-entry queue
        cmd_start = 1'b1; cmd_instr = 32'd1; step();
        chk("ov_cnt1", fifo_count, 32'd1); chk("ov_full1", cmd_full, 32'd0);
        cmd_instr = 32'd2; step();
        chk("ov_cnt2", fifo_count, 32'd2); chk("ov_full2", cmd_full, 32'd0);
        cmd_instr = 32'd3; step();
        chk("ov_cnt3", fifo_count, 32'd3); chk("ov_full3", cmd_full, 32'd1);
        cmd_instr = 32'd4; step();
        chk("ov_cnt4", fifo_count, 32'd4); chk("ov_err_before", err_overflow, 32'd0);
        cmd_instr = 32'd5; step();
        cmd_start = 1'b0;
        chk("ov_cnt_sat", fifo_count, 32'd4); chk("ov_err_set", err_overflow, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("ov_issue_valid", npu_cmd_valid, 32'd1);
            chk("ov_issue_data", npu_cmd_data, 32'(k));
            npu_cmd_ready = 1'b1; step(); npu_cmd_ready = 1'b0;
            chk("ov_pop_count", fifo_count, 32'(4 - k));
            npu_result_valid = 1'b1; npu_result = 32'(k + 100); step();
            npu_result_valid = 1'b0;
            chk("ov_rsp_data", rsp_data, 32'(k + 100));
            rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
            chk("ov_rsp_cleared", rsp_valid, 32'd0);
            step();
        end
        chk("ov_drained_busy", busy, 32'd0);
        chk("ov_err_sticky", err_overflow, 32'd1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("ov_err_clr", err_overflow, 32'd0);

        // Wrap-around streaming with ready/result/consume gaps
        sent = 0; issued = 0; rsp_n = 0; pend = 0; gap = 0; max_cnt = 0; inflight = 32'd0;
        for (int cyc = 0; cyc < 400 && rsp_n < 10; cyc++) begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            cmd_start = (sent < 10) && !cmd_full;
            cmd_instr = 32'hC0DE_0000 + 32'(sent);
            if (cmd_start) sent++;
            if (pend != 0 && gap == 0) begin
                npu_result_valid = 1'b1; npu_result = inflight ^ 32'h5A5A_0000; pend = 0;
            end else begin
                npu_result_valid = 1'b0;
                if (pend != 0) gap--;
            end
            npu_cmd_ready = (cyc % 3) != 1;
            if (npu_cmd_valid && npu_cmd_ready) begin
                chk("wrap_issue_order", npu_cmd_data, 32'hC0DE_0000 + 32'(issued));
                inflight = npu_cmd_data; issued++; pend = 1; gap = (issued % 3) + 1;
            end
            rsp_ready = (cyc % 2) == 0;
            if (rsp_valid && rsp_ready) begin
                chk("wrap_rsp_order", rsp_data, (32'hC0DE_0000 + 32'(rsp_n)) ^ 32'h5A5A_0000);
                rsp_n++;
            end
            step();
        end
        cmd_start = 1'b0; npu_cmd_ready = 1'b0; npu_result_valid = 1'b0; rsp_ready = 1'b0;
        chk("wrap_all_done", 32'(rsp_n), 32'd10);
        chk("wrap_max_count", 32'(max_cnt <= 4), 32'd1);
        chk("wrap_no_overflow", err_overflow, 32'd0);
        step();
        chk("wrap_idle", busy, 32'd0);

        // Asynchronous reset during WAIT with two commands queued
        cmd_start = 1'b1; cmd_instr = 32'h51; step();
        cmd_instr = 32'h52; step();
        cmd_instr = 32'h53; step();
        cmd_start = 1'b0; npu_cmd_ready = 1'b1; step(); npu_cmd_ready = 1'b0;
        chk("rst_pre_count", fifo_count, 32'd2);
        chk("rst_pre_busy", busy, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        @(posedge clk); #1 rst_n = 1'b1;
        npu_result_valid = 1'b1; npu_result = 32'hDEAD_BEEF; step();
        npu_result_valid = 1'b0;
        chk("rst_stray_rsp", rsp_valid, 32'd0);
        chk("rst_stray_busy", busy, 32'd0);
        step();
        chk("rst_stray_rsp2", rsp_valid, 32'd0);
        chk("rst_stray_cmd", npu_cmd_valid, 32'd0);

        // Result timeout (or indefinite WAIT without the feature)
        cmd_start = 1'b1; cmd_instr = 32'h61; step();
        cmd_start = 1'b0; step();
        npu_cmd_ready = 1'b1; step(); npu_cmd_ready = 1'b0;
        repeat (15) step();
        chk("to_not_yet", rsp_valid, 32'd0);
        step();
`ifdef NPU_CMD_TIMEOUT_EN
        chk("to_rsp_valid", rsp_valid, 32'd1);
        chk("to_rsp_data", rsp_data, 32'hFFFF_FFFF);
        chk("to_err", err_timeout, 32'd1);
`else
        chk("to_rsp_stays_low", rsp_valid, 32'd0);
        chk("to_err_tied", err_timeout, 32'd0);
        chk("to_still_busy", busy, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
